serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Sequences a single 1-bit full-adder cell (sum = a^b^c, carry = ab | c(a^b)) over WIDTH cycles to add or subtract two WIDTH-bit operands LSB-first.
- Captures operands through a valid/ready handshake, shifts bits through the cell, and holds the running carry in a flip-flop.
- Presents the assembled result and flags through a valid/ack handshake.
- Serves as the area-minimal arithmetic unit of the datapath where one adder cell is shared in time rather than replicated.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- op_a  input  WIDTH  first operand.
- op_b  input  WIDTH  second operand.
- op_sub  input  1  0 = A+B, 1 = A-B (two's complement).
- res_valid  output  1  result available.
- res_ack  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference.
- cout  output  1  final carry out of MSB (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.

Behaviour:
- One clock, one domain. Reset is synchronous and active-high; the ports are named clk and rst.
- Reset values:
  - state = IDLE, in_ready = 1, res_valid = 0, busy = 0.
  - result = 0, cout = 0, ovf = 0.
  - shift registers, counter and carry FF = 0.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - load shA = op_a, shB = op_b ^ {WIDTH{op_sub}}.
    - carry FF = op_sub, counter = 0, go to RUN.
  - RUN: busy = 1, in_ready = 0. Each cycle:
    - cell inputs are shA[0], shB[0] and carry FF.
    - sum bit is shifted into the result register MSB-side (result >> 1 with sum at [WIDTH-1]).
    - shA and shB shift right; carry FF takes the cell carry.
    - On the counter = WIDTH-1 cycle, also record cin_msb = carry FF value (pre-update); counter increments.
    - Transition: when counter = WIDTH-1, go to DONE next edge. cout = cell carry of that cycle, ovf = cin_msb ^ that carry.
  - DONE: res_valid = 1; result, cout and ovf stable. On res_ack go to IDLE. res_valid drops the following cycle, in_ready rises the same cycle.
- Latency: handshake edge to res_valid = WIDTH+1 clocks (WIDTH RUN cycles + transition into DONE). Throughput: one operation per WIDTH+2 clocks minimum when res_ack is tied high.
- Arithmetic: modulo 2^WIDTH. The subtract carry-in of 1 plus inverted B implements two's complement. A-B with A≥B (unsigned) gives cout = 1.
- Boundary conditions:
  - in_valid during RUN/DONE is ignored (in_ready = 0); the operand is not lost by the block but held by the producer.
  - res_ack in IDLE/RUN has no effect.
  - res_valid is never withdrawn without res_ack.
  - rst asserted in any state, including mid-RUN, returns everything to reset values on that edge. The partial result is discarded; no res_valid is produced.
  - No new operation may start in the same cycle res_ack is accepted; the new accept occurs at the earliest one cycle later.
  - Outputs result/cout/ovf retain the last value in IDLE until overwritten by the next RUN's final cycle. Only res_valid qualifies them.

Test Plan:
- Reset then idle: rst 2 cycles -> in_ready = 1, res_valid = 0, result = 0, cout = 0, ovf = 0.
- Add, WIDTH = 8: A = 0x5A, B = 0x33, op_sub = 0 -> after 9 clocks res_valid = 1, result = 0x8D, cout = 0, ovf = 1.
- Subtract with borrow: A = 0x10, B = 0x20, op_sub = 1 -> result = 0xF0, cout = 0, ovf = 0. Also A = 0x20, B = 0x10 -> result = 0x10, cout = 1.
- Wrap and carry: A = 0xFF, B = 0x01 add -> result = 0x00, cout = 1, ovf = 0. Also A = 0x7F, B = 0x01 -> result = 0x80, ovf = 1.
- Backpressure: hold res_ack = 0 for 5 cycles in DONE while pulsing in_valid with new operands -> result stable, in_ready = 0, second op accepted only after ack, and it yields the correct second result.
- Reset mid-RUN: assert rst at RUN cycle 4 -> next cycle IDLE, busy = 0, res_valid never asserts. A following op 0x01+0x01 yields 0x02.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The producer drives op_a/op_b/op_sub with in_valid; the block drives the result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             res_valid;
  logic             res_ack;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             busy;

  // Producer/consumer side (testbench or upstream/downstream logic)
  modport master (
    output in_valid, op_a, op_b, op_sub, res_ack,
    input  in_ready, res_valid, result, cout, ovf, busy
  );

  // Arithmetic block side
  modport slave (
    input  in_valid, op_a, op_b, op_sub, res_ack,
    output in_ready, res_valid, result, cout, ovf, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell is reused over WIDTH
// cycles, LSB first, with the running carry held in a flip-flop.
//
// Handshakes:
//   input side  - operands transfer on a rising edge where in_valid & in_ready;
//                 in_ready is high only in IDLE, and the producer must hold
//                 its operands while in_ready is low.
//   output side - res_valid rises in DONE and stays high until a rising edge
//                 with res_ack; result/cout/ovf are stable the whole time.
//                 The block returns to IDLE on that edge, so a new operand
//                 can be accepted no earlier than the following edge.
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;

  logic             cell_s;
  logic             cell_c;
  logic             last_bit;
  logic             accept;

  // The shared full-adder cell
  assign cell_s   = sh_a[0] ^ sh_b[0] ^ carry_q;
  assign cell_c   = (sh_a[0] & sh_b[0]) | (carry_q & (sh_a[0] ^ sh_b[0]));

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept   = (state_q == IDLE) && bus.in_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last_bit)     state_d = DONE;
      DONE:    if (bus.res_ack)  state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Datapath: operand load, serial shifting and final result capture.
  // The result port only changes on the last RUN cycle, so it keeps the
  // previous answer through IDLE and the early part of the next RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a     <= '0;
      sh_b     <= '0;
      sh_r     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with op_sub.
      sh_a    <= bus.op_a;
      sh_b    <= bus.op_b ^ {WIDTH{bus.op_sub}};
      carry_q <= bus.op_sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      sh_a    <= sh_a >> 1;
      sh_b    <= sh_b >> 1;
      sh_r    <= {cell_s, sh_r[WIDTH-1:1]};
      carry_q <= cell_c;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        result_q <= {cell_s, sh_r[WIDTH-1:1]};
        cout_q   <= cell_c;
        // carry_q still holds the carry into the MSB on this cycle.
        ovf_q    <= carry_q ^ cell_c;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.res_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: vector table, hand-written corner sequences,
// random operations, all checked through an expected-result queue.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;
  localparam int EW    = WIDTH + 2;   // {result, cout, ovf}

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;
  } vec_t;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [EW-1:0]   exp_q[$];
  logic [WIDTH-1:0] last_res;
  vec_t            vecs[8];

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer add of A and (B or ~B) plus op_sub.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   s;
    logic             v;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
    v  = (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {s[WIDTH-1:0], s[WIDTH], v};
  endfunction

  // Present operands, wait for acceptance; returns just after the accept edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic sub, input logic [EW-1:0] exp, input bit push);
    int t;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("send_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("accept_busy", {31'd0, bus.busy}, 32'd1);
  endtask

  // Wait (bounded) for res_valid and check the accept-to-valid latency.
  task automatic wait_valid(input int lat0);
    int lat;
    lat = lat0;
    while (!bus.res_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("res_valid", {31'd0, bus.res_valid}, 32'd1);
    check("latency", lat, WIDTH + 1);
  endtask

  // Pop the oldest expectation and compare against the presented result.
  task automatic pop_check();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: result with empty expected queue, got 0x%0h", bus.result);
    end else begin
      e = exp_q.pop_front();
      check("result", {24'd0, bus.result}, {24'd0, e[EW-1:2]});
      check("cout",   {31'd0, bus.cout},   {31'd0, e[1]});
      check("ovf",    {31'd0, bus.ovf},    {31'd0, e[0]});
      last_res = e[EW-1:2];
    end
  endtask

  // Acknowledge the result and check the return to IDLE.
  task automatic do_ack();
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
    check("ack_valid_drop", {31'd0, bus.res_valid}, 32'd0);
    check("ack_in_ready",   {31'd0, bus.in_ready},  32'd1);
    check("result_hold",    {24'd0, bus.result},    {24'd0, last_res});
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rs;
    int               seen;

    vecs[0] = '{a: 8'h5A, b: 8'h33, sub: 1'b0, res: 8'h8D, cout: 1'b0, ovf: 1'b1};
    vecs[1] = '{a: 8'h10, b: 8'h20, sub: 1'b1, res: 8'hF0, cout: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 8'h20, b: 8'h10, sub: 1'b1, res: 8'h10, cout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, res: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, res: 8'h80, cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h01, sub: 1'b1, res: 8'h7F, cout: 1'b1, ovf: 1'b1};
    vecs[6] = '{a: 8'h00, b: 8'h00, sub: 1'b1, res: 8'h00, cout: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 8'h00, b: 8'h01, sub: 1'b1, res: 8'hFF, cout: 1'b0, ovf: 1'b0};

    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.op_sub   = 1'b0;
    bus.res_ack  = 1'b0;
    last_res     = '0;

    // Reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_result",    {24'd0, bus.result},    32'd0);
    check("rst_cout",      {31'd0, bus.cout},      32'd0);
    check("rst_ovf",       {31'd0, bus.ovf},       32'd0);
    check("rst_state",     {30'd0, dbg_state},     32'd0);

    // res_ack while idle does nothing
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
    check("idle_ack_valid", {31'd0, bus.res_valid}, 32'd0);
    check("idle_ack_ready", {31'd0, bus.in_ready},  32'd1);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sub, {vecs[i].res, vecs[i].cout, vecs[i].ovf}, 1'b1);
      wait_valid(1);
      pop_check();
      do_ack();
    end

    // Backpressure: hold off res_ack while the producer offers a new operand
    send(8'h5A, 8'h33, 1'b0, model(8'h5A, 8'h33, 1'b0), 1'b1);
    wait_valid(1);
    bus.op_a     = 8'h20;
    bus.op_b     = 8'h10;
    bus.op_sub   = 1'b1;
    bus.in_valid = 1'b1;
    exp_q.push_back({8'h10, 1'b1, 1'b0});
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid",  {31'd0, bus.res_valid}, 32'd1);
      check("bp_ready",  {31'd0, bus.in_ready},  32'd0);
      check("bp_result", {24'd0, bus.result},    32'h8D);
    end
    pop_check();
    bus.res_ack = 1'b1;
    @(posedge clk); #1;
    bus.res_ack = 1'b0;
    check("bp_ack_ready", {31'd0, bus.in_ready}, 32'd1);
    check("bp_ack_busy",  {31'd0, bus.busy},     32'd0);
    check("bp_ack_valid", {31'd0, bus.res_valid}, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_second_accept", {31'd0, bus.busy}, 32'd1);
    wait_valid(1);
    pop_check();
    do_ack();

    // Reset in the middle of RUN
    send(8'h33, 8'h44, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_state",  {30'd0, dbg_state},     32'd0);
    check("mrst_busy",   {31'd0, bus.busy},      32'd0);
    check("mrst_ready",  {31'd0, bus.in_ready},  32'd1);
    check("mrst_result", {24'd0, bus.result},    32'd0);
    seen = 0;
    for (int c = 0; c < WIDTH + 4; c++) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1;
    end
    check("mrst_no_valid", seen, 0);
    send(8'h01, 8'h01, 1'b0, {8'h02, 1'b0, 1'b0}, 1'b1);
    wait_valid(1);
    pop_check();
    do_ack();

    // Random operations against the model
    for (int i = 0; i < 12; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, model(ra, rb, rs), 1'b1);
      wait_valid(1);
      pop_check();
      do_ack();
    end

    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
